// File: rtl/batched_axis_packet_router_pkg.sv
// batched_axis_packet_router_pkg: shared FSM state type and LOG2 helper for the batched packet router
package batched_axis_packet_router_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DROP, DONE} state_t;

    function automatic int log2(input int v);
        int r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/batched_axis_packet_router_batch_counter.sv
// bapr_batch_counter: per-batch packet counter; done when the batch is full or disabled
module bapr_batch_counter #(
    parameter int CHANNELS = 2,
    parameter int CW       = 2
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          inc,
    input  logic          enable,
    output logic [CW-1:0] count,
    output logic          done
);

    assign done = !enable || count == CW'(CHANNELS);

    // count accepted packets, never beyond CHANNELS
    always_ff @(posedge clk) begin
        if (rst || clear) count <= '0;
        else if (inc && count != CW'(CHANNELS)) count <= count + 1'b1;
    end

endmodule

// File: rtl/batched_axis_packet_router.sv
// batched_axis_packet_router: routes AXIS packets by tid to per-batch outputs; BATCHED_AXIS_PACKET_ROUTER_STATS_EN adds beat_count
module batched_axis_packet_router
    import batched_axis_packet_router_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int BATCH_SIZE = 2,
    parameter int DATA_WIDTH = 16,
    parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
    parameter int ID_WIDTH   = (log2(BATCH_SIZE) > 1) ? log2(BATCH_SIZE) : 1
)(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             operation_start,
    input  logic [BATCH_SIZE-1:0]            use_batch,
    input  logic                             interrupt,
    output logic                             operation_busy,
    output logic                             operation_complete,
    output logic                             operation_error,
    output logic                             transmission,
`ifdef BATCHED_AXIS_PACKET_ROUTER_STATS_EN
    output logic [31:0]                      beat_count,
`endif
    input  logic [DATA_WIDTH-1:0]            s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]            s_axis_tkeep,
    input  logic                             s_axis_tvalid,
    output logic                             s_axis_tready,
    input  logic                             s_axis_tlast,
    input  logic [ID_WIDTH-1:0]              s_axis_tid,
    output logic [BATCH_SIZE*DATA_WIDTH-1:0] m_axis_tdata,
    output logic [BATCH_SIZE*KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic [BATCH_SIZE-1:0]            m_axis_tvalid,
    input  logic [BATCH_SIZE-1:0]            m_axis_tready,
    output logic [BATCH_SIZE-1:0]            m_axis_tlast
);

    localparam int CW = log2(CHANNELS + 1);
    localparam int NR = 1 << ID_WIDTH;

    state_t                state, state_n;
    logic [BATCH_SIZE-1:0] use_r, done, done_n, inc;
    logic [CW-1:0]         cnt [BATCH_SIZE];
    logic [NR-1:0]         ok;
    logic [ID_WIDTH-1:0]   route, idx;
    logic                  err, mid, hit, run_ok, drop_ok, fire, acc, bad, clr;

    assign idx    = mid ? route : s_axis_tid;
    assign hit    = mid || ok[s_axis_tid];
    assign run_ok = !rst && state == RUN && !interrupt && !(&done);
    assign drop_ok = !rst && state == DROP && !interrupt;
    assign clr    = !rst && state == IDLE && operation_start;

    assign s_axis_tready = drop_ok || (run_ok && (hit ? m_axis_tready[idx] : 1'b1));
    assign fire          = s_axis_tvalid && s_axis_tready;
    assign acc           = run_ok && hit && fire;
    assign bad           = run_ok && !hit && s_axis_tvalid;
    assign transmission  = fire && state == RUN;

    assign operation_busy     = !rst && (state == RUN || state == DROP);
    assign operation_complete = !rst && state == DONE;
    assign operation_error    = !rst && err;

    assign m_axis_tdata = {BATCH_SIZE{s_axis_tdata}};
    assign m_axis_tkeep = {BATCH_SIZE{s_axis_tkeep}};
    assign m_axis_tlast = {BATCH_SIZE{s_axis_tlast}};

    for (genvar b = 0; b < NR; b++) begin : g_ok
        if (b < BATCH_SIZE) begin : g_in
            assign ok[b] = use_r[b] && !done[b];
        end else begin : g_out
            assign ok[b] = 1'b0;
        end
    end

    for (genvar b = 0; b < BATCH_SIZE; b++) begin : g_cnt
        assign inc[b]    = acc && s_axis_tlast && idx == ID_WIDTH'(b);
        assign done_n[b] = done[b] || (inc[b] && cnt[b] == CW'(CHANNELS - 1));
        bapr_batch_counter #(.CHANNELS(CHANNELS), .CW(CW)) u_cnt (
            .clk    (clk),
            .rst    (rst),
            .clear  (clr),
            .inc    (inc[b]),
            .enable (use_r[b]),
            .count  (cnt[b]),
            .done   (done[b])
        );
    end

    // only the lane selected by the current route sees the input valid
    always_comb begin
        m_axis_tvalid = '0;
        if (run_ok && hit) m_axis_tvalid[idx] = s_axis_tvalid;
    end

    // next state: interrupt first, then completion, then drop entry/exit
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = operation_start ? RUN : IDLE;
            RUN:     state_n = interrupt ? IDLE : (&done_n) ? DONE : (bad && !s_axis_tlast) ? DROP : RUN;
            DROP:    state_n = interrupt ? IDLE : (s_axis_tvalid && s_axis_tlast) ? RUN : DROP;
            default: state_n = IDLE;
        endcase
    end

    // state, batch enables, sticky error and packet route tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            use_r <= '0;
            err   <= 1'b0;
            mid   <= 1'b0;
            route <= '0;
        end else begin
            state <= state_n;
            if (clr) begin
                use_r <= use_batch;
                err   <= 1'b0;
                mid   <= 1'b0;
            end else begin
                if (((state == RUN || state == DROP) && interrupt) || bad) err <= 1'b1;
                if (acc) mid <= !s_axis_tlast;
                if (acc && !mid) route <= s_axis_tid;
                if (interrupt) mid <= 1'b0;
            end
        end
    end

`ifdef BATCHED_AXIS_PACKET_ROUTER_STATS_EN
    // saturating count of routed beats since the last start
    always_ff @(posedge clk) begin
        if (rst || clr) beat_count <= '0;
        else if (acc && beat_count != '1) beat_count <= beat_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_batched_axis_packet_router.sv
// tb_batched_axis_packet_router: scoreboard bench for the batched packet router
module tb_batched_axis_packet_router;

    logic        clk = 0, rst = 1, operation_start = 0, interrupt = 0;
    logic [1:0]  use_batch = 0;
    logic        operation_busy, operation_complete, operation_error, transmission;
    logic [15:0] s_axis_tdata = 0;
    logic [1:0]  s_axis_tkeep = 0;
    logic        s_axis_tvalid = 0, s_axis_tready, s_axis_tlast = 0;
    logic [0:0]  s_axis_tid = 0;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic [1:0]  m_axis_tvalid, m_axis_tlast;
    logic [1:0]  m_axis_tready = 2'b11;
`ifdef BATCHED_AXIS_PACKET_ROUTER_STATS_EN
    logic [31:0] beat_count;
`endif

    int n_cmp = 0, n_err = 0, n_complete = 0, pkts0 = 0, pkts1 = 0;
    bit no_valid = 0;
    logic [18:0] q0[$], q1[$];

    batched_axis_packet_router dut (
        .clk(clk), .rst(rst), .operation_start(operation_start), .use_batch(use_batch),
        .interrupt(interrupt), .operation_busy(operation_busy),
        .operation_complete(operation_complete), .operation_error(operation_error),
        .transmission(transmission),
`ifdef BATCHED_AXIS_PACKET_ROUTER_STATS_EN
        .beat_count(beat_count),
`endif
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tid(s_axis_tid),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] outs();
        return {operation_busy, operation_complete, operation_error, transmission, s_axis_tready, m_axis_tvalid};
    endfunction

    task automatic present(input int tid, input logic [15:0] d, input bit last, input bit routed);
        s_axis_tvalid = 1;
        s_axis_tid    = 1'(tid);
        s_axis_tdata  = d;
        s_axis_tkeep  = last ? 2'b01 : 2'b11;
        s_axis_tlast  = last;
        if (routed && tid == 0) q0.push_back({s_axis_tkeep, last, d});
        if (routed && tid == 1) q1.push_back({s_axis_tkeep, last, d});
    endtask

    task automatic handshake;
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!s_axis_tready && t < 100);
        if (!s_axis_tready) begin
            n_cmp++;
            n_err++;
            $display("FAIL hs_timeout: got tready=0 expected tready=1 within 100 cycles");
        end
        tick();
    endtask

    task automatic send_pkt(input int tid, input int n, input logic [15:0] base, input bit routed);
        for (int i = 0; i < n; i++) begin
            present(tid, base + 16'(i), i == n - 1, routed);
            handshake();
        end
        s_axis_tvalid = 0;
        s_axis_tlast  = 0;
    endtask

    task automatic start(input logic [1:0] u);
        operation_start = 1;
        use_batch       = u;
        tick();
        operation_start = 0;
    endtask

    // monitor: pop and compare every accepted output beat
    initial forever begin
        @(negedge clk);
        if (operation_complete) n_complete++;
        if (no_valid) chk("drop_no_valid", m_axis_tvalid, 0);
        for (int b = 0; b < 2; b++) begin
            if (m_axis_tvalid[b] && m_axis_tready[b]) begin
                if ((b == 0 ? q0.size() : q1.size()) == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_beat: lane %0d got data %0h expected no beat", b, m_axis_tdata[b*16 +: 16]);
                end else begin
                    logic [18:0] e;
                    e = (b == 0) ? q0.pop_front() : q1.pop_front();
                    chk("lane_beat", {m_axis_tkeep[b*2 +: 2], m_axis_tlast[b], m_axis_tdata[b*16 +: 16]}, e);
                    if (m_axis_tlast[b]) begin
                        if (b == 0) pkts0++;
                        else pkts1++;
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        chk("reset_outs_during", outs(), 0);
        repeat (3) tick();
        rst = 0;
        @(negedge clk);
        chk("reset_outs_after", outs(), 0);
        tick();

        // four 3-beat packets, stray start mid-run must be ignored
        start(2'b11);
        chk("t1_busy", operation_busy, 1);
        send_pkt(0, 3, 16'h1000, 1);
        send_pkt(1, 3, 16'h1100, 1);
        operation_start = 1;
        use_batch = 2'b00;
        tick();
        operation_start = 0;
        use_batch = 2'b11;
        send_pkt(0, 3, 16'h1200, 1);
        send_pkt(1, 3, 16'h1300, 1);
        chk("t1_complete", operation_complete, 1);
        chk("t1_error", operation_error, 0);
        tick();
        chk("t1_complete_gone", {operation_busy, operation_complete}, 0);
        chk("t1_lane_pkts", {pkts0[7:0], pkts1[7:0]}, 16'h0202);

        // disabled batch: single-beat and multi-beat drops, then valid traffic
        start(2'b01);
        no_valid = 1;
        send_pkt(1, 1, 16'h2000, 0);
        chk("t2_err_single", operation_error, 1);
        send_pkt(1, 3, 16'h2100, 0);
        no_valid = 0;
        send_pkt(0, 3, 16'h2200, 1);
        send_pkt(0, 1, 16'h2300, 1);
        chk("t2_complete", operation_complete, 1);
        tick();
        chk("t2_err_sticky", {operation_busy, operation_error}, 2'b01);

        // backpressure on lane 0 mid-packet
        start(2'b11);
        chk("t4_err_cleared", operation_error, 0);
        fork
            send_pkt(0, 5, 16'h4000, 1);
            begin
                repeat (2) @(posedge clk);
                #2 m_axis_tready = 2'b10;
                repeat (5) begin
                    @(negedge clk);
                    chk("t4_bp_tready", s_axis_tready, 0);
                    chk("t4_bp_transmission", transmission, 0);
                end
                @(posedge clk);
                #2 m_axis_tready = 2'b11;
            end
        join
        send_pkt(0, 3, 16'h4100, 1);
        send_pkt(1, 1, 16'h4200, 1);
        send_pkt(1, 1, 16'h4300, 1);
        chk("t4_complete", operation_complete, 1);
`ifdef BATCHED_AXIS_PACKET_ROUTER_STATS_EN
        chk("t4_beat_count", beat_count, 10);
`endif
        tick();

        // interrupt on second beat
        start(2'b11);
`ifdef BATCHED_AXIS_PACKET_ROUTER_STATS_EN
        chk("t5_beat_count_clr", beat_count, 0);
`endif
        present(0, 16'h5000, 0, 1);
        handshake();
        present(0, 16'h5001, 0, 0);
        interrupt = 1;
        m_axis_tready = 2'b00;
        tick();
        interrupt = 0;
        s_axis_tvalid = 0;
        m_axis_tready = 2'b11;
        chk("t5_after_irq", {operation_busy, operation_complete, operation_error}, 3'b001);
        tick();
        chk("t5_no_complete", operation_complete, 0);

        // empty batch set completes immediately
        start(2'b00);
        chk("t6_run", {operation_busy, operation_complete}, 2'b10);
        tick();
        chk("t6_done", {operation_busy, operation_complete, operation_error}, 3'b010);
        tick();
        chk("t6_idle", {operation_busy, operation_complete}, 0);

        // reset in the middle of a packet
        start(2'b11);
        present(1, 16'h8000, 0, 1);
        handshake();
        present(1, 16'h8001, 0, 0);
        rst = 1;
        @(negedge clk);
        chk("t8_outs_in_rst", outs(), 0);
        tick();
        tick();
        rst = 0;
        s_axis_tvalid = 0;
        chk("t8_outs_after_rst", outs(), 0);
        tick();
        chk("t8_no_complete", operation_complete, 0);

        chk("end_q0_empty", q0.size(), 0);
        chk("end_q1_empty", q1.size(), 0);
        chk("end_lane_pkts", {pkts0[7:0], pkts1[7:0]}, 16'h0604);
        chk("end_complete_pulses", n_complete, 4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
